// File: rtl/aer_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : aer_rx_fifo
// Purpose  : Receiver for the encoder's AER link. It completes the 4-phase
//            REQ/ACK handshake and stores each event address in a FIFO. The
//            FIFO feeds the SNN core through a valid/ready stream. While the
//            FIFO is full, ACK is withheld so that the encoder stalls.
// Ports    : CLK         clock, rising edge
//            RST         asynchronous reset, active low
//            AERIN_ADDR  event address from the encoder
//            AERIN_REQ   4-phase request from the encoder
//            AERIN_ACK   4-phase acknowledge to the encoder (registered)
//            EVT_ADDR    FIFO head address (0 when empty)
//            EVT_VALID   head entry present
//            EVT_READY   core consumes the head when VALID & READY
//            CLEAR       synchronous flush of FIFO and counter
//            FIFO_LEVEL  entries currently stored
//            EVT_COUNT   events accepted since reset/CLEAR (saturating)
// Options  : AER_SYNC_EN - define it to pass REQ (and ADDR) through a
//            2-flop synchroniser for an encoder on an unrelated clock.
// Revision : 1.0 - initial release
// ============================================================================
module aer_rx_fifo #(
  parameter int IMAGE_SIZE      = 526,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int FIFO_DEPTH      = 16,
  parameter int CNT_BITS        = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [IMAGE_SIZE_BITS+1:0]   AERIN_ADDR,
  input  logic                         AERIN_REQ,
  output logic                         AERIN_ACK,
  output logic [IMAGE_SIZE_BITS+1:0]   EVT_ADDR,
  output logic                         EVT_VALID,
  input  logic                         EVT_READY,
  input  logic                         CLEAR,
  output logic [$clog2(FIFO_DEPTH):0]  FIFO_LEVEL,
  output logic [CNT_BITS-1:0]          EVT_COUNT
);

  localparam int c_AW = IMAGE_SIZE_BITS + 2;
  localparam int c_IW = $clog2(FIFO_DEPTH);
  localparam int c_PW = c_IW + 1;

  // --------------------------------------------------------------------------
  // Request conditioning
  // --------------------------------------------------------------------------
  logic            w_req_s;
  logic [c_AW-1:0] w_addr_s;

`ifdef AER_SYNC_EN
  // The address travels through the same number of stages as REQ. The
  // encoder holds ADDR stable while REQ is high, so when the synchronised
  // REQ is first seen high the delayed address is already settled.
  logic            r_req_meta;
  logic            r_req_sync;
  logic [c_AW-1:0] r_addr_meta;
  logic [c_AW-1:0] r_addr_sync;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_req_meta  <= 1'b0;
      r_req_sync  <= 1'b0;
      r_addr_meta <= '0;
      r_addr_sync <= '0;
    end else begin
      r_req_meta  <= AERIN_REQ;
      r_req_sync  <= r_req_meta;
      r_addr_meta <= AERIN_ADDR;
      r_addr_sync <= r_addr_meta;
    end
  end

  assign w_req_s  = r_req_sync;
  assign w_addr_s = r_addr_sync;
`else
  assign w_req_s  = AERIN_REQ;
  assign w_addr_s = AERIN_ADDR;
`endif

  // --------------------------------------------------------------------------
  // FIFO pointers and flags
  // --------------------------------------------------------------------------
  logic [c_AW-1:0] r_mem [FIFO_DEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_PW-1:0] w_rd_nxt;
  logic [c_AW-1:0] r_head;
  logic            r_valid;
  logic            w_valid_nxt;
  logic            w_full;
  logic            w_push;
  logic            w_pop;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACKD = 1'b1
  } state_t;

  state_t          r_state;
  logic            r_ack;
  logic [CNT_BITS-1:0] r_count;

  assign w_full = (r_wr_ptr[c_PW-1] != r_rd_ptr[c_PW-1]) &&
                  (r_wr_ptr[c_IW-1:0] == r_rd_ptr[c_IW-1:0]);

  // A push is the IDLE->ACKD transition itself; when full it is simply not
  // taken, and the held request is retried on every later IDLE cycle.
  assign w_push   = (r_state == S_IDLE) && w_req_s && !w_full;
  // r_valid implies at least one stored entry, so no separate empty guard.
  assign w_pop    = r_valid && EVT_READY;
  assign w_rd_nxt = r_rd_ptr + {{(c_PW-1){1'b0}}, w_pop};

  // The output view is built from the pre-edge write pointer, so a new
  // entry shows up one cycle after its write edge, while the entry after a
  // popped head is presented straight away (no bubble between entries).
  assign w_valid_nxt = (r_wr_ptr != w_rd_nxt);

  // --------------------------------------------------------------------------
  // Handshake FSM; CLEAR deliberately leaves it alone
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_push) begin
            r_state <= S_ACKD;
            r_ack   <= 1'b1;
          end
        end
        S_ACKD: begin
          if (!w_req_s) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Storage (no reset needed: contents are only read behind valid pointers)
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (w_push && !CLEAR) begin
      r_mem[r_wr_ptr[c_IW-1:0]] <= w_addr_s;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else if (CLEAR) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + {{(c_PW-1){1'b0}}, w_push};
      r_rd_ptr <= w_rd_nxt;
      r_valid  <= w_valid_nxt;
      r_head   <= w_valid_nxt ? r_mem[w_rd_nxt[c_IW-1:0]] : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Accepted-event counter, saturating
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count <= '0;
    end else if (CLEAR) begin
      r_count <= '0;
    end else if (w_push && (r_count != {CNT_BITS{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign AERIN_ACK  = r_ack;
  assign EVT_ADDR   = r_head;
  assign EVT_VALID  = r_valid;
  assign FIFO_LEVEL = r_wr_ptr - r_rd_ptr;
  assign EVT_COUNT  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_aer_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_aer_rx_fifo
// Purpose  : Self-checking bench for aer_rx_fifo. Expected addresses are
//            queued when a request is driven; a negedge monitor pops and
//            compares each event the core side consumes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aer_rx_fifo;

  localparam int c_AW  = 12;   // $clog2(526) + 2
  localparam int c_CNT = 5;    // narrow counter so saturation is reachable
  localparam int c_TMO = 40;
`ifdef AER_SYNC_EN
  localparam int c_LAT = 3;
`else
  localparam int c_LAT = 1;
`endif

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [c_AW-1:0]  AERIN_ADDR = '0;
  logic             AERIN_REQ = 1'b0;
  logic             AERIN_ACK;
  logic [c_AW-1:0]  EVT_ADDR;
  logic             EVT_VALID;
  logic             EVT_READY = 1'b0;
  logic             CLEAR = 1'b0;
  logic [4:0]       FIFO_LEVEL;
  logic [c_CNT-1:0] EVT_COUNT;

  int n_tests = 0;
  int n_fail  = 0;
  logic [c_AW-1:0] r_sb [$];

  aer_rx_fifo #(
    .IMAGE_SIZE (526),
    .FIFO_DEPTH (16),
    .CNT_BITS   (c_CNT)
  ) u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .AERIN_ADDR (AERIN_ADDR),
    .AERIN_REQ  (AERIN_REQ),
    .AERIN_ACK  (AERIN_ACK),
    .EVT_ADDR   (EVT_ADDR),
    .EVT_VALID  (EVT_VALID),
    .EVT_READY  (EVT_READY),
    .CLEAR      (CLEAR),
    .FIFO_LEVEL (FIFO_LEVEL),
    .EVT_COUNT  (EVT_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input string tag);
    int k = 0;
    while ((AERIN_ACK !== lvl) && (k < c_TMO)) begin
      step();
      k++;
    end
    chk(tag, int'(AERIN_ACK), int'(lvl));
  endtask

  task automatic send(input logic [c_AW-1:0] addr);
    AERIN_ADDR = addr;
    AERIN_REQ  = 1'b1;
    r_sb.push_back(addr);
    wait_ack(1'b1, "ack_rise");
    AERIN_REQ  = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  task automatic drain;
    int k = 0;
    EVT_READY = 1'b1;
    while ((EVT_VALID || (r_sb.size() != 0)) && (k < 200)) begin
      step();
      k++;
    end
    EVT_READY = 1'b0;
    chk("drain_sb_empty", r_sb.size(), 0);
    chk("drain_level", int'(FIFO_LEVEL), 0);
  endtask

  // Consumer-side monitor, sampled half a cycle away from the active edge.
  always @(negedge CLK) begin
    if (RST && EVT_VALID && EVT_READY) begin
      if (r_sb.size() == 0) chk("evt_unexpected", int'(EVT_VALID), 0);
      else                  chk("evt_order", int'(EVT_ADDR), int'(r_sb.pop_front()));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit done;
    done = 1'b0;

    // ---- reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ack", int'(AERIN_ACK), 0);
    chk("rst_valid", int'(EVT_VALID), 0);
    chk("rst_addr", int'(EVT_ADDR), 0);
    chk("rst_level", int'(FIFO_LEVEL), 0);
    chk("rst_count", int'(EVT_COUNT), 0);
    RST = 1'b1;
    step();
    step();

    // ---- single event with exact latencies
    AERIN_ADDR = 12'h05A;
    AERIN_REQ  = 1'b1;
    r_sb.push_back(12'h05A);
    for (int i = 1; i <= c_LAT; i++) begin
      step();
      chk("single_ack_rise_lat", int'(AERIN_ACK), (i == c_LAT) ? 1 : 0);
    end
    chk("single_valid_not_yet", int'(EVT_VALID), 0);
    step();
    chk("single_valid", int'(EVT_VALID), 1);
    chk("single_addr", int'(EVT_ADDR), 'h05A);
    chk("single_count", int'(EVT_COUNT), 1);
    chk("single_level", int'(FIFO_LEVEL), 1);
    step();
    AERIN_REQ = 1'b0;
    for (int i = 1; i <= c_LAT; i++) begin
      step();
      chk("single_ack_fall_lat", int'(AERIN_ACK), (i < c_LAT) ? 1 : 0);
    end
    drain();

    // ---- backpressure: fill, 17th request is held off until one pop
    for (int a = 0; a < 16; a++) send(12'(a));
    chk("bp_level_full", int'(FIFO_LEVEL), 16);
    chk("bp_count", int'(EVT_COUNT), 17);
    AERIN_ADDR = 12'd16;
    AERIN_REQ  = 1'b1;
    r_sb.push_back(12'd16);
    repeat (c_LAT + 4) step();
    chk("bp_no_ack_when_full", int'(AERIN_ACK), 0);
    chk("bp_level_held", int'(FIFO_LEVEL), 16);
    EVT_READY = 1'b1;
    step();
    EVT_READY = 1'b0;
    begin
      int k = 0;
      while (!AERIN_ACK && (k < 2)) begin
        step();
        k++;
      end
    end
    chk("bp_ack_after_pop", int'(AERIN_ACK), 1);
    AERIN_REQ = 1'b0;
    wait_ack(1'b0, "bp_ack_fall");
    chk("bp_count_after", int'(EVT_COUNT), 18);
    drain();

    // ---- concurrent push and pop at level 3
    for (int a = 0; a < 3; a++) send(12'h100 + 12'(a));
    chk("cc_level_before", int'(FIFO_LEVEL), 3);
    AERIN_ADDR = 12'h103;
    AERIN_REQ  = 1'b1;
    r_sb.push_back(12'h103);
    repeat (c_LAT - 1) step();
    EVT_READY = 1'b1;
    step();
    EVT_READY = 1'b0;
    chk("cc_level_same", int'(FIFO_LEVEL), 3);
    chk("cc_ack", int'(AERIN_ACK), 1);
    AERIN_REQ = 1'b0;
    wait_ack(1'b0, "cc_ack_fall");
    chk("cc_count", int'(EVT_COUNT), 22);
    drain();

    // ---- CLEAR while in ACKD with level 5
    for (int a = 0; a < 4; a++) send(12'h200 + 12'(a));
    AERIN_ADDR = 12'h204;
    AERIN_REQ  = 1'b1;
    r_sb.push_back(12'h204);
    wait_ack(1'b1, "clr_ack_rise");
    chk("clr_level_before", int'(FIFO_LEVEL), 5);
    CLEAR = 1'b1;
    r_sb.delete();
    step();
    CLEAR = 1'b0;
    chk("clr_level", int'(FIFO_LEVEL), 0);
    chk("clr_count", int'(EVT_COUNT), 0);
    chk("clr_valid", int'(EVT_VALID), 0);
    chk("clr_ack_kept", int'(AERIN_ACK), 1);
    repeat (2) step();
    chk("clr_ack_held", int'(AERIN_ACK), 1);
    AERIN_REQ = 1'b0;
    wait_ack(1'b0, "clr_ack_fall");

    // ---- write on the same edge as CLEAR is discarded
    AERIN_ADDR = 12'h2AA;
    AERIN_REQ  = 1'b1;
    repeat (c_LAT - 1) step();
    CLEAR = 1'b1;
    step();
    CLEAR = 1'b0;
    chk("clrw_ack", int'(AERIN_ACK), 1);
    chk("clrw_level", int'(FIFO_LEVEL), 0);
    chk("clrw_count", int'(EVT_COUNT), 0);
    step();
    chk("clrw_valid", int'(EVT_VALID), 0);
    AERIN_REQ = 1'b0;
    wait_ack(1'b0, "clrw_ack_fall");

    // ---- counter saturation (31 for a 5-bit counter)
    EVT_READY = 1'b1;
    for (int a = 0; a < 35; a++) send(12'h300 + 12'(a));
    drain();
    chk("sat_count", int'(EVT_COUNT), 31);

    // ---- random traffic with random consumer stalls
    fork
      begin
        for (int n = 0; n < 1000; n++) send(12'($urandom_range(0, 4095)));
        done = 1'b1;
      end
      begin
        while (!done) begin
          step();
          EVT_READY = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    // ---- asynchronous reset mid-handshake
    send(12'h3C0);
    send(12'h3C1);
    AERIN_ADDR = 12'h3C2;
    AERIN_REQ  = 1'b1;
    wait_ack(1'b1, "arst_ack_rise");
    chk("arst_valid_before", int'(EVT_VALID), 1);
    #2;
    RST = 1'b0;
    r_sb.delete();
    #1;
    chk("arst_ack", int'(AERIN_ACK), 0);
    chk("arst_valid", int'(EVT_VALID), 0);
    chk("arst_level", int'(FIFO_LEVEL), 0);
    chk("arst_count", int'(EVT_COUNT), 0);
    AERIN_REQ = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
